// File: rtl/image_loader.sv
// image_loader: captures weight bytes then packed binary pixel bytes into registered frame outputs.
// Optional IMAGE_LOADER_CHECKSUM_EN appends a trailing XOR check byte to each frame.
module image_loader #(
    parameter int N_WEIGHT_BYTES = 9,
    parameter int N_PIXEL_BYTES  = 98
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [2:0]                    state,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic [8*N_PIXEL_BYTES-1:0]    pixels,
    output logic [8*N_WEIGHT_BYTES-1:0]   weights,
    output logic                          load_done,
`ifdef IMAGE_LOADER_CHECKSUM_EN
    output logic                          load_err,
`endif
    output logic [6:0]                    byte_count
);
    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_LOAD = 3'b001;
    localparam logic [6:0] LAST_W = 7'(N_WEIGHT_BYTES - 1);
    localparam logic [6:0] LAST_P = 7'(N_WEIGHT_BYTES + N_PIXEL_BYTES - 1);

    typedef enum logic [2:0] {
        L_IDLE, L_WEIGHTS, L_PIXELS, L_DONE
`ifdef IMAGE_LOADER_CHECKSUM_EN
        , L_CHECK
`endif
    } lstate_t;

    lstate_t                        fsm_q, fsm_d;
    logic [6:0]                     cnt_q, cnt_d;
    logic [8*N_PIXEL_BYTES-1:0]     pixels_q, pixels_d;
    logic [8*N_WEIGHT_BYTES-1:0]    weights_q, weights_d;
    logic [6:0]                     pix_idx;
    logic [9:0]                     pix_base, wt_base;
    logic                           accept;
`ifdef IMAGE_LOADER_CHECKSUM_EN
    logic                           err_q, err_d;
    logic [7:0]                     csum_q, csum_d;
    assign load_err   = err_q;
    assign data_ready = state == S_LOAD && (fsm_q == L_WEIGHTS || fsm_q == L_PIXELS || fsm_q == L_CHECK);
`else
    assign data_ready = state == S_LOAD && (fsm_q == L_WEIGHTS || fsm_q == L_PIXELS);
`endif

    assign accept     = data_valid && data_ready;
    assign pix_idx    = cnt_q - 7'(N_WEIGHT_BYTES);
    assign pix_base   = {pix_idx, 3'b000};
    assign wt_base    = {cnt_q, 3'b000};
    assign pixels     = pixels_q;
    assign weights    = weights_q;
    assign byte_count = cnt_q;
    assign load_done  = fsm_q == L_DONE;

    always_comb begin
        fsm_d     = fsm_q;
        cnt_d     = cnt_q;
        pixels_d  = pixels_q;
        weights_d = weights_q;
`ifdef IMAGE_LOADER_CHECKSUM_EN
        err_d     = err_q;
        csum_d    = accept ? csum_q ^ data_in : csum_q;
`endif
        if (state == S_IDLE) begin
            fsm_d = L_IDLE;
            cnt_d = '0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
            err_d  = 1'b0;
            csum_d = '0;
`endif
        end else if (fsm_q == L_IDLE) begin
            fsm_d = state == S_LOAD ? L_WEIGHTS : L_IDLE;
        end else if (accept && fsm_q == L_WEIGHTS) begin
            weights_d[wt_base +: 8] = data_in;
            cnt_d = cnt_q + 7'd1;
            fsm_d = cnt_q == LAST_W ? L_PIXELS : L_WEIGHTS;
        end else if (accept && fsm_q == L_PIXELS) begin
            pixels_d[pix_base +: 8] = data_in;
`ifdef IMAGE_LOADER_CHECKSUM_EN
            cnt_d = cnt_q + 7'd1;
            fsm_d = cnt_q == LAST_P ? L_CHECK : L_PIXELS;
        end else if (accept && fsm_q == L_CHECK) begin
            // A bad check byte discards the frame and waits for a resend.
            fsm_d  = data_in == csum_q ? L_DONE : L_WEIGHTS;
            err_d  = err_q || data_in != csum_q;
            cnt_d  = data_in == csum_q ? cnt_q : '0;
            csum_d = '0;
`else
            cnt_d = cnt_q == LAST_P ? cnt_q : cnt_q + 7'd1;
            fsm_d = cnt_q == LAST_P ? L_DONE : L_PIXELS;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q     <= L_IDLE;
            cnt_q     <= '0;
            pixels_q  <= '0;
            weights_q <= '0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
            err_q     <= 1'b0;
            csum_q    <= '0;
`endif
        end else begin
            fsm_q     <= fsm_d;
            cnt_q     <= cnt_d;
            pixels_q  <= pixels_d;
            weights_q <= weights_d;
`ifdef IMAGE_LOADER_CHECKSUM_EN
            err_q     <= err_d;
            csum_q    <= csum_d;
`endif
        end
    end
endmodule

// File: tb/tb_image_loader.sv
// tb_image_loader: table vectors, directed frames and randomized traffic against a byte-count model.
module tb_image_loader;
    localparam logic [2:0] S_IDLE = 3'b000, S_LOAD = 3'b001, S_L1 = 3'b010, S_L2 = 3'b011, S_L3 = 3'b100;
`ifdef IMAGE_LOADER_CHECKSUM_EN
    localparam int FRAME = 108;
`else
    localparam int FRAME = 107;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   state = S_LOAD;
    logic [7:0]   data_in = '0;
    logic         data_valid = 1'b1;
    logic         data_ready;
    logic [783:0] pixels;
    logic [71:0]  weights;
    logic         load_done;
    logic [6:0]   byte_count;
`ifdef IMAGE_LOADER_CHECKSUM_EN
    logic         load_err;
`endif

    image_loader dut (
        .clk(clk), .rst_n(rst_n), .state(state), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .pixels(pixels), .weights(weights), .load_done(load_done),
`ifdef IMAGE_LOADER_CHECKSUM_EN
        .load_err(load_err),
`endif
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    bit entered;
    int n_acc;
    logic [7:0] mw [9];
    logic [7:0] mp [98];
    logic [7:0] fr [108];

    typedef struct {
        bit         rn;
        logic [2:0] st;
        bit         v;
        logic [7:0] d;
        bit         er;
        int         ebc;
        bit         ed;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string nm, input logic [783:0] act, input logic [783:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [783:0] exp_pix();
        logic [783:0] r;
        for (int p = 0; p < 784; p++) r[p] = mp[p/8][p%8];
        return r;
    endfunction

    function automatic logic [71:0] exp_wts();
        logic [71:0] r;
        for (int i = 0; i < 72; i++) r[i] = mw[i/8][i%8];
        return r;
    endfunction

    task automatic model_clear();
        entered = 0;
        n_acc = 0;
        for (int i = 0; i < 9; i++) mw[i] = '0;
        for (int i = 0; i < 98; i++) mp[i] = '0;
    endtask

    task automatic set_csum();
        logic [7:0] x = '0;
        for (int i = 0; i < 107; i++) x ^= fr[i];
        fr[107] = x;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; state = S_LOAD; data_valid = 1'b1; data_in = 8'($urandom);
        @(posedge clk);
        model_clear();
        #1;
        chk("rst_ready", data_ready, 0);
        chk("rst_count", byte_count, 0);
        chk("rst_done", load_done, 0);
        chk("rst_pixels", pixels, 0);
        chk("rst_weights", weights, 0);
`ifdef IMAGE_LOADER_CHECKSUM_EN
        chk("rst_err", load_err, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1; state = S_IDLE; data_valid = 1'b0;
    endtask

    // One clock with the model advanced by the rules: count accepts, cap reported count at frame end.
    task automatic step(input logic [2:0] st, input logic v, input logic [7:0] d);
        bit er, acc;
        @(negedge clk);
        state = st; data_valid = v; data_in = d;
        #1;
        er = st == S_LOAD && entered && n_acc < FRAME;
        chk("data_ready", data_ready, er);
        acc = v && er;
        @(posedge clk);
        if (st == S_IDLE) begin
            entered = 0;
            n_acc = 0;
        end else if (!entered) begin
            if (st == S_LOAD) entered = 1;
        end else if (acc) begin
            if (n_acc < 9) mw[n_acc] = d;
            else if (n_acc < 107) mp[n_acc-9] = d;
            n_acc++;
        end
        #1;
        chk("byte_count", byte_count, n_acc == FRAME ? FRAME - 1 : n_acc);
        chk("load_done", load_done, n_acc == FRAME);
    endtask

    task automatic send_frame(input int pct, input bit exc, input int upto);
        int cyc = 0;
        bit done_exc = 0;
        while (n_acc < upto && cyc < 3000) begin
            if (exc && !done_exc && n_acc == 50) begin
                repeat (5) step(S_L2, 1'($urandom), 8'($urandom));
                done_exc = 1;
            end
            step(S_LOAD, $urandom_range(99, 0) < pct, fr[n_acc]);
            cyc++;
        end
        if (n_acc < upto) chk("frame_timeout", n_acc, upto);
    endtask

    initial begin
        logic [783:0] one_hot;
        tbl[0]  = '{0, S_LOAD, 1, 8'h55, 0, 0, 0};
        tbl[1]  = '{1, S_IDLE, 1, 8'h11, 0, 0, 0};
        tbl[2]  = '{1, S_LOAD, 1, 8'h22, 0, 0, 0};
        tbl[3]  = '{1, S_LOAD, 1, 8'h01, 1, 1, 0};
        tbl[4]  = '{1, S_LOAD, 0, 8'h77, 1, 1, 0};
        tbl[5]  = '{1, S_L2,   1, 8'h33, 0, 1, 0};
        tbl[6]  = '{1, S_LOAD, 1, 8'h02, 1, 2, 0};
        tbl[7]  = '{1, S_IDLE, 1, 8'h03, 0, 0, 0};
        tbl[8]  = '{1, S_LOAD, 0, 8'h00, 0, 0, 0};
        tbl[9]  = '{1, S_LOAD, 1, 8'h0A, 1, 1, 0};
        tbl[10] = '{0, S_LOAD, 1, 8'h0B, 1, 0, 0};
        repeat (3) @(posedge clk);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            rst_n = tbl[i].rn; state = tbl[i].st; data_valid = tbl[i].v; data_in = tbl[i].d;
            #1;
            chk("tbl_ready", data_ready, tbl[i].er);
            @(posedge clk);
            #1;
            chk("tbl_count", byte_count, tbl[i].ebc);
            chk("tbl_done", load_done, tbl[i].ed);
            if (i == 9) chk("tbl_weights_retained", weights, 72'h020A);
        end
        chk("tbl_weights_reset", weights, 0);
        do_reset();

        for (int i = 0; i < 9; i++) fr[i] = 8'(i + 1);
        for (int i = 9; i < 107; i++) fr[i] = 8'hA5;
        set_csum();
        send_frame(100, 0, FRAME);
        chk("full_weights", weights, 72'h090807060504030201);
        chk("full_pixels", pixels, {98{8'hA5}});
        repeat (3) step(S_LOAD, 1, 8'($urandom));
        repeat (3) step(S_L1, 1, 8'($urandom));
        chk("full_pixels_held", pixels, {98{8'hA5}});

        step(S_IDLE, 1, 8'h00);
        chk("restart_pixels", pixels, {98{8'hA5}});
        for (int i = 0; i < 9; i++) fr[i] = 8'($urandom);
        for (int i = 9; i < 107; i++) fr[i] = 8'h00;
        fr[106] = 8'h80;
        set_csum();
        send_frame(100, 0, FRAME);
        one_hot = '0;
        one_hot[783] = 1'b1;
        chk("map_pixels", pixels, one_hot);
        chk("map_weights", weights, exp_wts());

        step(S_IDLE, 0, 8'h00);
        for (int i = 9; i < 107; i++) fr[i] = 8'hFF;
        set_csum();
        send_frame(100, 0, FRAME);
        chk("ones_pixels", pixels, {784{1'b1}});

        step(S_IDLE, 0, 8'h00);
        for (int i = 0; i < 107; i++) fr[i] = 8'($urandom);
        set_csum();
        send_frame(60, 1, FRAME);
        chk("gap_pixels", pixels, exp_pix());
        chk("gap_weights", weights, exp_wts());
        step(S_L3, 1, 8'($urandom));

        for (int i = 0; i < 400; i++)
            step(3'($urandom_range(4, 0)), 1'($urandom),
                 n_acc < FRAME ? fr[n_acc] : 8'($urandom));
        chk("rand_pixels", pixels, exp_pix());
        chk("rand_weights", weights, exp_wts());

        step(S_IDLE, 0, 8'h00);
        send_frame(80, 0, 20);
        do_reset();

`ifdef IMAGE_LOADER_CHECKSUM_EN
        for (int i = 0; i < 107; i++) fr[i] = 8'($urandom);
        set_csum();
        send_frame(100, 0, 107);
        @(negedge clk);
        state = S_LOAD; data_valid = 1'b1; data_in = fr[107] ^ 8'h5A;
        @(posedge clk);
        #1;
        chk("bad_csum_err", load_err, 1);
        chk("bad_csum_done", load_done, 0);
        chk("bad_csum_count", byte_count, 0);
        n_acc = 0;
        send_frame(100, 0, FRAME);
        chk("resend_done", load_done, 1);
        chk("resend_err_sticky", load_err, 1);
        chk("resend_pixels", pixels, exp_pix());
        step(S_IDLE, 0, 8'h00);
        chk("idle_err_clear", load_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
